scan_frame_tx: RTL

- Downstream stage of the echo scanner core; sits between the measurement pipeline and the CoreUART transmit side.
- Buffers (angle, distance) samples produced during one servo sweep.
- On end of sweep, emits one framed, checksummed packet through the CoreUART txrdy/wen/data_in handshake.
- Replaces byte-at-a-time reporting, so a host receives a whole sweep atomically.

---
 rtl/scan_frame_tx_if.sv | 25 ++
 rtl/scan_frame_tx.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/scan_frame_tx_if.sv
// Bundle between the echo scanner measurement pipeline, the frame
// transmitter and the CoreUART transmit side.
interface scan_frame_tx_if;
  logic       sample_valid;
  logic [7:0] sample_angle;
  logic [7:0] sample_distance;
  logic       sweep_done;
  logic       txrdy;
  logic       wen;
  logic [7:0] data_in;
  logic       busy;
  logic       frame_done;

  // Transmitter side: consumes samples, writes bytes into CoreUART.
  modport master (
    input  sample_valid, sample_angle, sample_distance, sweep_done, txrdy,
    output wen, data_in, busy, frame_done
  );

  // Environment side: produces samples, plays the CoreUART role.
  modport slave (
    output sample_valid, sample_angle, sample_distance, sweep_done, txrdy,
    input  wen, data_in, busy, frame_done
  );
endinterface

// File: rtl/scan_frame_tx.sv
// Sweep frame transmitter: buffers (angle, distance) pairs during a servo
// sweep and, on sweep_done, sends A5, flags, count, payload, checksum
// through the CoreUART txrdy/wen/data_in handshake.
module scan_frame_tx #(
  parameter int DEPTH  = 32,
  parameter int TX_GAP = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  scan_frame_tx_if.master bus
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] HEADER  = 8'hA5;
  localparam logic [7:0] DEPTH_B = 8'(DEPTH);
  localparam logic [7:0] GAP_B   = 8'(TX_GAP);

  typedef enum logic {FILL, SEND} state_t;

  state_t     state_reg, state_next;
  logic [7:0] count_reg, count_next;
  logic       overflow_reg, overflow_next;
  logic       lost_reg, lost_next;
  logic [7:0] flags_reg, flags_next;
  logic [9:0] idx_reg, idx_next;
  logic [7:0] csum_reg, csum_next;
  logic [7:0] gap_reg, gap_next;
  logic [7:0] hold_reg, hold_next;

  logic [7:0] angle_mem [DEPTH];
  logic [7:0] dist_mem  [DEPTH];

  logic          store;
  logic [9:0]    last_idx;
  logic [9:0]    pay_idx;
  logic [AW-1:0] rd_addr;
  logic [7:0]    cur_byte;
  logic          wen_c;
  logic          frame_done_c;

  // Samples are only accepted while filling and while there is room.
  assign store    = (state_reg == FILL) && bus.sample_valid && (count_reg < DEPTH_B);
  // Index of the checksum byte: header, flags, count, 2*count payload.
  assign last_idx = {1'b0, count_reg, 1'b0} + 10'd3;
  assign pay_idx  = idx_reg - 10'd3;
  assign rd_addr  = AW'(pay_idx >> 1);

  // Sample buffer write port; contents are never cleared, count tracks validity.
  always_ff @(posedge clk) begin
    if (store) begin
      angle_mem[AW'(count_reg)] <= bus.sample_angle;
      dist_mem[AW'(count_reg)]  <= bus.sample_distance;
    end
  end

  // Select the byte the frame is currently positioned at.
  always_comb begin
    cur_byte = HEADER;
    if (idx_reg == 10'd0)          cur_byte = HEADER;
    else if (idx_reg == 10'd1)     cur_byte = flags_reg;
    else if (idx_reg == 10'd2)     cur_byte = count_reg;
    else if (idx_reg == last_idx)  cur_byte = csum_reg;
    else if (pay_idx[0])           cur_byte = dist_mem[rd_addr];
    else                           cur_byte = angle_mem[rd_addr];
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= FILL;
      count_reg    <= 8'd0;
      overflow_reg <= 1'b0;
      lost_reg     <= 1'b0;
      flags_reg    <= 8'd0;
      idx_reg      <= 10'd0;
      csum_reg     <= 8'd0;
      gap_reg      <= 8'd0;
      hold_reg     <= 8'd0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      lost_reg     <= lost_next;
      flags_reg    <= flags_next;
      idx_reg      <= idx_next;
      csum_reg     <= csum_next;
      gap_reg      <= gap_next;
      hold_reg     <= hold_next;
    end
  end

  // Next-state logic: fill the buffer, then pace bytes out under txrdy and the gap.
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    lost_next     = lost_reg;
    flags_next    = flags_reg;
    idx_next      = idx_reg;
    csum_next     = csum_reg;
    hold_next     = hold_reg;
    gap_next      = (gap_reg != 8'd0) ? gap_reg - 8'd1 : 8'd0;
    wen_c         = 1'b0;
    frame_done_c  = 1'b0;

    case (state_reg)
      FILL: begin
        if (bus.sample_valid) begin
          if (count_reg < DEPTH_B) count_next    = count_reg + 8'd1;
          else                     overflow_next = 1'b1;
        end
        // A sample arriving with sweep_done is already folded in above.
        if (bus.sweep_done) begin
          flags_next    = {6'b0, lost_reg, overflow_next};
          overflow_next = 1'b0;
          lost_next     = 1'b0;
          idx_next      = 10'd0;
          csum_next     = 8'd0;
          state_next    = SEND;
        end
      end
      SEND: begin
        if (bus.sample_valid) lost_next = 1'b1;
        if (bus.txrdy && (gap_reg == 8'd0)) begin
          wen_c     = 1'b1;
          hold_next = cur_byte;
          gap_next  = GAP_B;
          idx_next  = idx_reg + 10'd1;
          if (idx_reg != 10'd0) csum_next = csum_reg ^ cur_byte;
          if (idx_reg == last_idx) begin
            frame_done_c = 1'b1;
            count_next   = 8'd0;
            state_next   = FILL;
          end
        end
      end
      default: state_next = FILL;
    endcase
  end

  assign bus.wen        = wen_c;
  assign bus.data_in    = wen_c ? cur_byte : hold_reg;
  assign bus.busy       = (state_reg == SEND);
  assign bus.frame_done = frame_done_c;

endmodule
